manchester_deser: RTL and testbench
===================================

MANCHESTER_DESER -- requirements
Module: manchester_deser

Interface
REQ-001 Parameter OSR, default 8, meaning clk samples per Manchester chip; power of two, at least 4.
REQ-002 Parameter SYNC_CHIPS, default 16'h9A65, meaning the 16-chip frame sync pattern (decodes to 8'hB4 under 10=1, 01=0).
REQ-003 Parameter FRAME_WORDS, default 4, meaning payload words per frame after sync; range 1..255.
REQ-004 clk  input  1  the single clock; all logic is rising-edge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 rx_in  input  1  raw asynchronous receiver chip line.
REQ-007 chips  output  16  payload chip word, first-received chip in bit 15; feeds the Manchester pair decoder.
REQ-008 chips_valid  output  1  chips holds an unconsumed word.
REQ-009 chips_ready  input  1  downstream accepts chips this cycle.
REQ-010 frame_start  output  1  one-cycle pulse when SYNC_CHIPS is matched.
REQ-011 code_err  output  1  one-cycle pulse on an illegal chip pair (00 or 11) in a payload word.
REQ-012 overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-013 busy  output  1  high while state is not HUNT.

Function
REQ-014 rx_in SHALL pass through a 2-flop synchronizer; all further logic SHALL use the second stage, rx_s.
REQ-015 An edge is rx_s differing from its 1-cycle delayed copy.
REQ-016 Phase counter (log2 OSR bits): on an edge it loads 1; otherwise it increments and wraps OSR-1 -> 0.
REQ-017 A chip strobe SHALL occur in the cycle the phase counter equals OSR/2; on the strobe, rx_s shifts into bit 0 of a 16-bit chip shift register.
REQ-018 An idle counter SHALL clear on every edge; after 3*OSR consecutive edge-free cycles the FSM SHALL return to HUNT with no output.
REQ-019 FSM states: HUNT, PAYLOAD.
REQ-020 HUNT: after each chip strobe, if the shift register equals SYNC_CHIPS, pulse frame_start, clear chip and word counters, and go to PAYLOAD.
REQ-021 PAYLOAD: on the 16th chip strobe the word is complete; the word counter increments; after FRAME_WORDS words go to HUNT.
REQ-022 Each completed word SHALL be checked pairwise (bits [2k+1:2k]); any 00 or 11 pair pulses code_err, discards the word, and goes to HUNT.
REQ-023 A legal word SHALL load chips and set chips_valid the cycle after completion (latency 1 clk from the completing strobe).
REQ-024 chips_valid SHALL stay high, with chips stable, until a cycle with chips_ready high; it then clears unless a new word loads in that same cycle.
REQ-025 Completion while chips_valid=1 and chips_ready=0 SHALL pulse overrun and drop the new word; the held word is unchanged and the frame continues.
REQ-026 Completion in the same cycle as acceptance (valid and ready both high) SHALL load the new word, keep chips_valid high, and raise no overrun.
REQ-027 Sync detection SHALL NOT occur in PAYLOAD; a sync-equal payload word is delivered as data.

Reset
REQ-028 While rst=1: state HUNT; all counters, shift register and synchronizer cleared; chips=16'h0000; chips_valid, frame_start, code_err, overrun, busy = 0.
REQ-029 rst asserted mid-frame or mid-handshake SHALL discard any pending word; after release the block hunts for a fresh sync.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the default SYNC_CHIPS value and the chip-pair legality function.
REQ-031 Sub-module chip_sampler (synchronizer, edge detect, phase counter, idle timeout, strobe) is natural; FSM, shift register and output register stay in manchester_deser.

Verification
REQ-032 OSR=8: send chips 9A65, then 16'h6A95 with chips_ready=1 -> frame_start pulses once; chips=16'h6A95 and chips_valid for 1 clk.
REQ-033 FRAME_WORDS=2: sync, 16'hAAAA, then 16'h5555 -> two words delivered, busy drops after the 2nd word, a 3rd word is ignored.
REQ-034 Payload 16'hAAAB (pair 11 in bits [1:0]) -> code_err pulses, no chips_valid, state HUNT.
REQ-035 chips_ready=0 through two payload words -> first word held, overrun pulses at second completion, first word delivered when ready rises.
REQ-036 rx_in held constant for 3*OSR clk mid-payload -> busy falls, no output; a new sync is then accepted.
REQ-037 rst pulsed for 1 clk during chip 8 of a payload word -> all outputs 0 next cycle; no word emitted until a new sync.

Source files
------------

// File: rtl/manchester_deser_pkg.sv
// Shared types and helpers for the Manchester chip deserializer.
package manchester_deser_pkg;

  // Receiver FSM: HUNT searches for the sync pattern, PAYLOAD collects words.
  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  // Sync pattern 1001101001100101 decodes to 8'hB4 with 10=1, 01=0.
  localparam logic [15:0] SYNC_CHIPS_DEFAULT = 16'h9A65;

  // A Manchester chip pair is legal only when its two chips differ.
  function automatic logic pair_legal(input logic [1:0] pair);
    return pair[1] ^ pair[0];
  endfunction

  // A 16-chip word is legal when all eight pairs [2k+1:2k] are legal.
  function automatic logic word_legal(input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ok = ok & pair_legal(w[2*k +: 2]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/manchester_deser_chip_sampler.sv
// Line front end: synchronizer, edge detect, phase tracking, mid-chip
// strobe and idle timeout for the Manchester deserializer.
module manchester_deser_chip_sampler #(
  parameter int OSR = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s_o,
  output logic strobe_o,
  output logic idle_timeout_o
);

  localparam int PW = $clog2(OSR);
  localparam int IW = $clog2(3 * OSR + 1);
  localparam logic [PW-1:0] PHASE_MID  = PW'(OSR / 2);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(3 * OSR);

  logic          sync1_q, sync2_q, rx_dly_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          edge_det;

  // Two-flop synchronizer plus a delayed copy of the second stage for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      rx_dly_q <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      rx_dly_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ rx_dly_q;

  // Phase re-aligns to 1 on every edge, otherwise free-runs modulo OSR;
  // idle counter saturates at the timeout limit and clears on edges.
  always_comb begin
    phase_d = phase_q + 1'b1;
    idle_d  = idle_q;
    if (edge_det) begin
      phase_d = PW'(1);
      idle_d  = '0;
    end else if (idle_q != IDLE_LIMIT) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Phase and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      idle_q  <= '0;
    end else begin
      phase_q <= phase_d;
      idle_q  <= idle_d;
    end
  end

  assign rx_s_o         = sync2_q;
  assign strobe_o       = (phase_q == PHASE_MID);
  assign idle_timeout_o = (idle_q == IDLE_LIMIT);

endmodule

// File: rtl/manchester_deser.sv
// Manchester chip deserializer: hunts for a 16-chip sync pattern, then
// delivers FRAME_WORDS 16-chip payload words over a valid/ready port.
//
// Handshake: chips_valid rises when a word is loaded and then holds, with
// chips stable, until a cycle where chips_ready is high; that cycle is the
// transfer. A word completing while the held word is not being taken is
// dropped with an overrun pulse; a word completing in the transfer cycle
// replaces the held word and chips_valid stays high.
module manchester_deser
  import manchester_deser_pkg::*;
#(
  parameter int          OSR         = 8,
  parameter logic [15:0] SYNC_CHIPS  = SYNC_CHIPS_DEFAULT,
  parameter int          FRAME_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [15:0] chips,
  output logic        chips_valid,
  input  logic        chips_ready,
  output logic        frame_start,
  output logic        code_err,
  output logic        overrun,
  output logic        busy
);

  localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);

  logic        rx_s, strobe, idle_timeout;
  state_e      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  chip_cnt_q, chip_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [15:0] chips_q, chips_d;
  logic        valid_q, valid_d;
  logic        frame_start_q, frame_start_d;
  logic        code_err_q, code_err_d;
  logic        overrun_q, overrun_d;

  manchester_deser_chip_sampler #(
    .OSR(OSR)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .rx_s_o        (rx_s),
    .strobe_o      (strobe),
    .idle_timeout_o(idle_timeout)
  );

  // Chip shift register input: newest chip enters bit 0 on each strobe.
  assign sr_d = strobe ? {sr_q[14:0], rx_s} : sr_q;

  // Next-state, counters, word check and output handshake.
  always_comb begin
    state_d       = state_q;
    chip_cnt_d    = chip_cnt_q;
    word_cnt_d    = word_cnt_q;
    chips_d       = chips_q;
    valid_d       = valid_q & ~chips_ready;
    frame_start_d = 1'b0;
    code_err_d    = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      HUNT: begin
        if (strobe && (sr_d == SYNC_CHIPS)) begin
          frame_start_d = 1'b1;
          chip_cnt_d    = '0;
          word_cnt_d    = '0;
          state_d       = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (idle_timeout) begin
          state_d = HUNT;
        end else if (strobe) begin
          chip_cnt_d = chip_cnt_q + 1'b1;
          if (chip_cnt_q == 4'd15) begin
            if (!word_legal(sr_d)) begin
              code_err_d = 1'b1;
              state_d    = HUNT;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              if (word_cnt_q == LAST_WORD) begin
                state_d = HUNT;
              end
              if (valid_q && !chips_ready) begin
                overrun_d = 1'b1;
              end else begin
                chips_d = sr_d;
                valid_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      chip_cnt_q    <= '0;
      word_cnt_q    <= '0;
      chips_q       <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      code_err_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      chip_cnt_q    <= chip_cnt_d;
      word_cnt_q    <= word_cnt_d;
      chips_q       <= chips_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      code_err_q    <= code_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign chips       = chips_q;
  assign chips_valid = valid_q;
  assign frame_start = frame_start_q;
  assign code_err    = code_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != HUNT);

endmodule

// File: tb/tb_manchester_deser.sv
// Directed bench for manchester_deser (OSR=8, FRAME_WORDS=2).
module tb_manchester_deser;

  localparam int          OSR  = 8;
  localparam int          FW   = 2;
  localparam logic [15:0] SYNC = 16'h9A65;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_in;
  logic        chips_ready;
  logic [15:0] chips;
  logic        chips_valid, frame_start, code_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor block)
  int cyc = 0;
  int fs_cnt = 0, ce_cnt = 0, ov_cnt = 0, v_cnt = 0;
  int fs_cyc = 0, vrise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [15:0] got_q[$];

  // Scoreboard
  logic [15:0] exp_q[$];
  int got_idx = 0;

  typedef struct {
    logic [15:0] word;
    logic        legal;
  } vec_t;
  vec_t tbl[8];

  manchester_deser #(
    .OSR        (OSR),
    .SYNC_CHIPS (SYNC),
    .FRAME_WORDS(FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .chips      (chips),
    .chips_valid(chips_valid),
    .chips_ready(chips_ready),
    .frame_start(frame_start),
    .code_err   (code_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt <= fs_cnt + 1;
      fs_cyc <= cyc;
    end
    if (code_err) ce_cnt <= ce_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (chips_valid) v_cnt <= v_cnt + 1;
    if (chips_valid && !prev_valid) vrise_cyc <= cyc;
    if (chips_valid && chips_ready) got_q.push_back(chips);
    prev_valid <= chips_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare delivered words since the last call against the expected queue
  task automatic score(input string name);
    check({name, "_count"}, 32'(got_q.size() - got_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_idx < got_q.size()) begin
      check({name, "_word"}, 32'(got_q[got_idx]), 32'(exp_q.pop_front()));
      got_idx++;
    end
    got_idx = got_q.size();
    exp_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rx_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    got_idx = got_q.size();
  endtask

  task automatic send_chip(input logic c);
    rx_in = c;
    tick(OSR);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_chip(w[i]);
  endtask

  int fs0, ce0, ov0, v0, t;
  logic [15:0] w2;

  initial begin
    // Reset state
    rst = 1'b1;
    rx_in = 1'b0;
    chips_ready = 1'b0;
    tick(3);
    check("reset_outputs", 32'({chips, chips_valid, frame_start, code_err, overrun, busy}), 0);
    rst = 1'b0;
    tick(2);

    // Single-word frames: legality, delivery, latency, busy
    tbl[0] = '{16'h6A95, 1'b1};
    tbl[1] = '{16'hAAAA, 1'b1};
    tbl[2] = '{16'h5555, 1'b1};
    tbl[3] = '{16'h9A65, 1'b1};
    tbl[4] = '{16'h6996, 1'b1};
    tbl[5] = '{16'hAAAB, 1'b0};
    tbl[6] = '{16'h2AAA, 1'b0};
    tbl[7] = '{16'hA5A4, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      chips_ready = 1'b1;
      fs0 = fs_cnt; ce0 = ce_cnt; v0 = v_cnt;
      send_word(SYNC);
      send_word(tbl[i].word);
      tick(4);
      check("tbl_frame_start", 32'(fs_cnt - fs0), 1);
      check("tbl_code_err", 32'(ce_cnt - ce0), tbl[i].legal ? 1 - 1 : 1);
      check("tbl_valid_cycles", 32'(v_cnt - v0), tbl[i].legal ? 1 : 0);
      check("tbl_busy", 32'(busy), 32'(tbl[i].legal));
      if (tbl[i].legal) begin
        exp_q.push_back(tbl[i].word);
        check("tbl_latency", 32'(vrise_cyc - fs_cyc), 16 * OSR);
      end
      score("tbl");
    end

    // Two-word frame, third word ignored
    do_reset();
    chips_ready = 1'b1;
    fs0 = fs_cnt;
    send_word(SYNC);
    check("frame_busy_high", 32'(busy), 1);
    send_word(16'hAAAA);
    send_word(16'h5555);
    tick(4);
    check("frame_busy_end", 32'(busy), 0);
    send_word(16'h6A95);
    tick(4);
    check("frame_single_sync", 32'(fs_cnt - fs0), 1);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h5555);
    score("frame");

    // Overrun: ready low through two words
    do_reset();
    chips_ready = 1'b0;
    ov0 = ov_cnt;
    send_word(SYNC);
    send_word(16'hAAAA);
    send_word(16'h5555);
    tick(4);
    check("ovr_pulse", 32'(ov_cnt - ov0), 1);
    check("ovr_valid_held", 32'(chips_valid), 1);
    check("ovr_chips_held", 32'(chips), 32'h0000AAAA);
    score("ovr_none_yet");
    chips_ready = 1'b1;
    tick(2);
    check("ovr_valid_cleared", 32'(chips_valid), 0);
    exp_q.push_back(16'hAAAA);
    score("ovr_deliver");

    // Completion in the same cycle as acceptance
    do_reset();
    chips_ready = 1'b0;
    fs0 = fs_cnt; ov0 = ov_cnt;
    fork
      begin
        send_word(SYNC);
        send_word(16'hAAAA);
        send_word(16'h5555);
      end
      begin
        t = 0;
        while (fs_cnt == fs0 && t < 2000) begin
          tick(1);
          t++;
        end
        check("same_sync_seen", 32'(fs_cnt - fs0), 1);
        while (cyc < fs_cyc + 16 * OSR * 2 - 1) tick(1);
        chips_ready = 1'b1;
        tick(1);
        chips_ready = 1'b0;
        check("same_valid", 32'(chips_valid), 1);
        check("same_chips", 32'(chips), 32'h00005555);
      end
    join
    tick(4);
    check("same_no_overrun", 32'(ov_cnt - ov0), 0);
    chips_ready = 1'b1;
    tick(2);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h5555);
    score("same");

    // Idle line mid-payload drops back to HUNT; new sync accepted
    do_reset();
    chips_ready = 1'b1;
    fs0 = fs_cnt; v0 = v_cnt;
    send_word(SYNC);
    w2 = 16'h6A95;
    for (int i = 15; i >= 8; i--) send_chip(w2[i]);
    check("idle_busy_before", 32'(busy), 1);
    rx_in = 1'b0;
    tick(4 * OSR);
    check("idle_busy_after", 32'(busy), 0);
    check("idle_no_output", 32'(v_cnt - v0), 0);
    send_word(SYNC);
    send_word(16'h5555);
    tick(4);
    check("idle_resync", 32'(fs_cnt - fs0), 2);
    exp_q.push_back(16'h5555);
    score("idle");

    // Reset pulse during chip 8 of a payload word with a word pending
    do_reset();
    chips_ready = 1'b0;
    send_word(SYNC);
    send_word(16'h6A95);
    check("rst_pending", 32'(chips_valid), 1);
    w2 = 16'h5555;
    for (int i = 15; i >= 9; i--) send_chip(w2[i]);
    rx_in = w2[8];
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_outputs", 32'({chips, chips_valid, frame_start, code_err, overrun, busy}), 0);
    tick(OSR - 2);
    for (int i = 7; i >= 0; i--) send_chip(w2[i]);
    rx_in = 1'b0;
    tick(5 * OSR);
    chips_ready = 1'b1;
    tick(4);
    check("rst_busy", 32'(busy), 0);
    score("rst_discard");
    fs0 = fs_cnt;
    send_word(SYNC);
    send_word(16'h6996);
    tick(4);
    check("rst_resync", 32'(fs_cnt - fs0), 1);
    exp_q.push_back(16'h6996);
    score("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
